// File: rtl/xc_malu_pdiv.sv
// xc_malu_pdiv: packed per-lane restoring divider for the XCrypto MALU.
// Lane width is one-hot (pw[0]=32 .. pw[4]=2). The divider produces one quotient
// bit per cycle, and all lanes iterate in parallel.
// Optional feature macro: XC_MALU_PDIV_SIGNED_EN. When it is defined, op_signed
// selects signed per-lane division with magnitude conversion and sign fix-up.
//
// state | meaning
// IDLE  | waiting for a request with a one-hot pw
// BUSY  | one restoring-division step per cycle, W steps in total
// DONE  | results loaded, ready pulses for this cycle only
module xc_malu_pdiv (
    input  logic        g_clk,
    input  logic        g_resetn,
    input  logic        valid,
    input  logic        flush,
    input  logic [31:0] rs1,
    input  logic [31:0] rs2,
    input  logic [4:0]  pw,
    input  logic        op_signed,
    output logic        busy,
    output logic        ready,
    output logic [31:0] result_q,
    output logic [31:0] result_r
);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    function automatic logic [31:0] lsb_mask(input logic [4:0] w);
        case (w)
            5'b00010: return 32'h0001_0001;
            5'b00100: return 32'h0101_0101;
            5'b01000: return 32'h1111_1111;
            5'b10000: return 32'h5555_5555;
            default:  return 32'h0000_0001;
        endcase
    endfunction

    function automatic logic [31:0] msb_mask(input logic [4:0] w);
        case (w)
            5'b00010: return 32'h8000_8000;
            5'b00100: return 32'h8080_8080;
            5'b01000: return 32'h8888_8888;
            5'b10000: return 32'hAAAA_AAAA;
            default:  return 32'h8000_0000;
        endcase
    endfunction

    function automatic logic [5:0] last_step(input logic [4:0] w);
        case (w)
            5'b00010: return 6'd15;
            5'b00100: return 6'd7;
            5'b01000: return 6'd3;
            5'b10000: return 6'd1;
            default:  return 6'd31;
        endcase
    endfunction

    // Copy each lane's msb value to every bit of that lane.
    function automatic logic [31:0] lane_spread(input logic [31:0] v, input logic [31:0] msb);
        logic [31:0] s;
        s[31] = v[31];
        for (int i = 30; i >= 0; i--) s[i] = msb[i] ? v[i] : s[i+1];
        return s;
    endfunction

    // Per-lane a - b with the borrow chain broken at each lane lsb; returns {borrow, diff}.
    function automatic logic [63:0] lane_sub(input logic [31:0] a, input logic [31:0] b,
                                             input logic [31:0] lsb);
        logic [31:0] d;
        logic [31:0] bo;
        logic        c;
        c = 1'b0;
        for (int i = 0; i < 32; i++) begin
            if (lsb[i]) c = 1'b0;
            d[i]  = a[i] ^ b[i] ^ c;
            bo[i] = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & c);
            c     = bo[i];
        end
        return {bo, d};
    endfunction

    // Two's-complement negate the lanes whose bits are set in neg.
    function automatic logic [31:0] lane_neg(input logic [31:0] x, input logic [31:0] neg,
                                             input logic [31:0] lsb);
        logic [31:0] y;
        logic        c;
        c = 1'b0;
        for (int i = 0; i < 32; i++) begin
            if (lsb[i]) c = 1'b1;
            y[i] = neg[i] ? (~x[i] ^ c) : x[i];
            c    = c & ~x[i];
        end
        return y;
    endfunction

    // Per-lane "value is non-zero", copied to every bit of the lane.
    function automatic logic [31:0] lane_nz(input logic [31:0] v, input logic [31:0] lsb,
                                            input logic [31:0] msb);
        logic [31:0] t;
        logic        acc;
        acc = 1'b0;
        for (int i = 0; i < 32; i++) begin
            if (lsb[i]) acc = 1'b0;
            acc  = acc | v[i];
            t[i] = acc;
        end
        return lane_spread(t, msb);
    endfunction

    state_t      state_q, state_d;
    logic        busy_q, busy_d, ready_q, ready_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [4:0]  pw_q, pw_d;
    logic [31:0] dvd_q, dvd_d, dvs_q, dvs_d, rem_q, rem_d, quo_q, quo_d;
    logic [31:0] res_quo_q, res_quo_d, res_rem_q, res_rem_d;

    logic        pw_ok, accept;
    logic [31:0] lsb_w, msb_w;
    logic [5:0]  wm1_w;
    logic [31:0] r_sh, sub_diff, sub_bout, take, rem_nx, quo_nx, dvd_nx;
    logic [31:0] op_a, op_b, fix_quo, fix_rem;

    assign pw_ok  = (pw != 5'd0) && ((pw & (pw - 5'd1)) == 5'd0);
    assign accept = (state_q == S_IDLE) && valid && pw_ok && !flush;

    assign lsb_w = lsb_mask(pw_q);
    assign msb_w = msb_mask(pw_q);
    assign wm1_w = last_step(pw_q);

    // One restoring step. The remainder can drop its lane msb on the shift:
    // before the last step it is always below 2^(W-1).
    assign r_sh                 = ((rem_q << 1) & ~lsb_w) | ((dvd_q & msb_w) >> wm1_w);
    assign {sub_bout, sub_diff} = lane_sub(r_sh, dvs_q, lsb_w);
    assign take                 = ~lane_spread(sub_bout, msb_w);
    assign rem_nx               = (sub_diff & take) | (r_sh & ~take);
    assign quo_nx               = ((quo_q << 1) & ~lsb_w) | (take & lsb_w);
    assign dvd_nx               = (dvd_q << 1) & ~lsb_w;

`ifdef XC_MALU_PDIV_SIGNED_EN
    logic [31:0] lsb_in, msb_in, sgn_a, sgn_b, dvs_nz;
    logic [31:0] qneg_q, qneg_d, rneg_q, rneg_d;

    assign lsb_in  = lsb_mask(pw);
    assign msb_in  = msb_mask(pw);
    assign sgn_a   = op_signed ? lane_spread(rs1, msb_in) : 32'd0;
    assign sgn_b   = op_signed ? lane_spread(rs2, msb_in) : 32'd0;
    assign dvs_nz  = lane_nz(rs2, lsb_in, msb_in);
    assign op_a    = lane_neg(rs1, sgn_a, lsb_in);
    assign op_b    = lane_neg(rs2, sgn_b, lsb_in);
    assign fix_quo = lane_neg(quo_nx, qneg_q, lsb_w);
    assign fix_rem = lane_neg(rem_nx, rneg_q, lsb_w);

    // Sign fix-up flags are captured on accept. A zero divisor leaves the
    // quotient at -1.
    always_comb begin
        qneg_d = qneg_q;
        rneg_d = rneg_q;
        if (accept) begin
            qneg_d = (sgn_a ^ sgn_b) & dvs_nz;
            rneg_d = sgn_a;
        end
    end

    // Sign flag registers.
    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            qneg_q <= 32'd0;
            rneg_q <= 32'd0;
        end else begin
            qneg_q <= qneg_d;
            rneg_q <= rneg_d;
        end
    end
`else
    logic unused_op_signed;
    assign unused_op_signed = op_signed;
    assign op_a    = rs1;
    assign op_b    = rs2;
    assign fix_quo = quo_nx;
    assign fix_rem = rem_nx;
`endif

    // Next-state and datapath update. Flush overrides everything except reset.
    always_comb begin
        state_d   = state_q;
        busy_d    = busy_q;
        ready_d   = ready_q;
        cnt_d     = cnt_q;
        pw_d      = pw_q;
        dvd_d     = dvd_q;
        dvs_d     = dvs_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        res_quo_d = res_quo_q;
        res_rem_d = res_rem_q;
        if (flush) begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
            ready_d = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        state_d = S_BUSY;
                        busy_d  = 1'b1;
                        ready_d = 1'b0;
                        cnt_d   = 6'd0;
                        pw_d    = pw;
                        dvd_d   = op_a;
                        dvs_d   = op_b;
                        rem_d   = 32'd0;
                        quo_d   = 32'd0;
                    end
                end
                S_BUSY: begin
                    dvd_d = dvd_nx;
                    rem_d = rem_nx;
                    quo_d = quo_nx;
                    cnt_d = cnt_q + 6'd1;
                    if (cnt_q == wm1_w) begin
                        state_d   = S_DONE;
                        busy_d    = 1'b0;
                        ready_d   = 1'b1;
                        res_quo_d = fix_quo;
                        res_rem_d = fix_rem;
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                    ready_d = 1'b0;
                end
                default: begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                    ready_d = 1'b0;
                end
            endcase
        end
    end

    // State, working and result registers.
    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            state_q   <= S_IDLE;
            busy_q    <= 1'b0;
            ready_q   <= 1'b0;
            cnt_q     <= 6'd0;
            pw_q      <= 5'b00001;
            dvd_q     <= 32'd0;
            dvs_q     <= 32'd0;
            rem_q     <= 32'd0;
            quo_q     <= 32'd0;
            res_quo_q <= 32'd0;
            res_rem_q <= 32'd0;
        end else begin
            state_q   <= state_d;
            busy_q    <= busy_d;
            ready_q   <= ready_d;
            cnt_q     <= cnt_d;
            pw_q      <= pw_d;
            dvd_q     <= dvd_d;
            dvs_q     <= dvs_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            res_quo_q <= res_quo_d;
            res_rem_q <= res_rem_d;
        end
    end

    assign busy     = busy_q;
    assign ready    = ready_q;
    assign result_q = res_quo_q;
    assign result_r = res_rem_q;

endmodule

// File: tb/tb_xc_malu_pdiv.sv
// Testbench for xc_malu_pdiv: directed vectors feed a scoreboard queue, and a
// negedge monitor checks results and latency on every ready pulse.
module tb_xc_malu_pdiv;

    localparam logic [4:0] P32 = 5'b00001;
    localparam logic [4:0] P16 = 5'b00010;
    localparam logic [4:0] P8  = 5'b00100;
    localparam logic [4:0] P4  = 5'b01000;
    localparam logic [4:0] P2  = 5'b10000;

    logic        g_clk = 1'b0;
    logic        g_resetn = 1'b0;
    logic        valid = 1'b0;
    logic        flush = 1'b0;
    logic        op_signed = 1'b0;
    logic [31:0] rs1 = 32'd0;
    logic [31:0] rs2 = 32'd0;
    logic [4:0]  pw = 5'd0;
    logic        busy, ready;
    logic [31:0] result_q, result_r;

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        int          acc;
        int          lat;
    } exp_t;

    exp_t sb_q[$];
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    int   n_done = 0;

    xc_malu_pdiv dut (
        .g_clk     (g_clk),
        .g_resetn  (g_resetn),
        .valid     (valid),
        .flush     (flush),
        .rs1       (rs1),
        .rs2       (rs2),
        .pw        (pw),
        .op_signed (op_signed),
        .busy      (busy),
        .ready     (ready),
        .result_q  (result_q),
        .result_r  (result_r)
    );

    always #5 g_clk = ~g_clk;
    always @(posedge g_clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every ready pulse must match the oldest expectation.
    always @(negedge g_clk) begin
        exp_t e;
        if (g_resetn && ready) begin
            chk("busy_with_ready", {31'd0, busy}, 32'd0);
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ready: got q=%h r=%h expected no pulse", result_q, result_r);
            end else begin
                e = sb_q.pop_front();
                chk("quotient", result_q, e.q);
                chk("remainder", result_r, e.r);
                chk("latency", 32'(cyc - e.acc + 1), 32'(e.lat));
                n_done++;
            end
        end
    end

    // Drive a request from posedge+1; it is accepted at the next edge.
    task automatic issue(input logic [4:0] p, input logic [31:0] a, input logic [31:0] b,
                         input logic s, input logic [31:0] eq, input logic [31:0] er,
                         input int lat, input bit push, input bit keep);
        exp_t e;
        pw = p; rs1 = a; rs2 = b; op_signed = s; valid = 1'b1;
        @(posedge g_clk);
        #1;
        e.q = eq; e.r = er; e.acc = cyc; e.lat = lat;
        if (push) sb_q.push_back(e);
        chk("busy_after_accept", {31'd0, busy}, 32'd1);
        if (!keep) valid = 1'b0;
    endtask

    task automatic wait_done(input int target);
        int k;
        k = 0;
        while (n_done < target && k < 60) begin
            @(posedge g_clk);
            k++;
        end
        #1;
        checks++;
        if (n_done < target) begin
            errors++;
            $display("FAIL completion_timeout: got %0d done expected %0d", n_done, target);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] exp_sq, exp_sr, exp_tq, exp_tr;
`ifdef XC_MALU_PDIV_SIGNED_EN
        exp_sq = 32'h8000FFFD; exp_sr = 32'h0000FFFF;
        exp_tq = 32'h80FFFDD7; exp_tr = 32'h00F90100;
`else
        exp_sq = 32'h00007FFC; exp_sr = 32'h80000001;
        exp_tq = 32'h00FF002C; exp_tr = 32'h80F90701;
`endif
        repeat (3) @(posedge g_clk);
        #1;
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_ready", {31'd0, ready}, 32'd0);
        chk("reset_result_q", result_q, 32'd0);
        chk("reset_result_r", result_r, 32'd0);
        @(negedge g_clk);
        g_resetn = 1'b1;
        @(posedge g_clk);
        #1;

        issue(P32, 32'd100, 32'd7, 1'b0, 32'h0000000E, 32'h00000002, 33, 1'b1, 1'b0);
        wait_done(1);

        // Second 32-bit op, flushed in cycle 5; results must keep op 1.
        issue(P32, 32'd1000, 32'd3, 1'b0, 32'd0, 32'd0, 33, 1'b0, 1'b0);
        repeat (4) @(posedge g_clk);
        #1 flush = 1'b1;
        @(posedge g_clk);
        #1 flush = 1'b0;
        chk("flush_busy", {31'd0, busy}, 32'd0);
        chk("flush_ready", {31'd0, ready}, 32'd0);
        chk("flush_hold_q", result_q, 32'h0000000E);
        chk("flush_hold_r", result_r, 32'h00000002);

        issue(P8, 32'h64FF1007, 32'h07100300, 1'b0, 32'h0E0F05FF, 32'h020F0107, 9, 1'b1, 1'b0);
        wait_done(2);
        issue(P16, 32'h8000FFF9, 32'hFFFF0002, 1'b1, exp_sq, exp_sr, 17, 1'b1, 1'b0);
        wait_done(3);
        issue(P2, 32'hFFFFFFFF, 32'h55555555, 1'b0, 32'hFFFFFFFF, 32'h00000000, 3, 1'b1, 1'b0);
        wait_done(4);

        // Valid held through BUSY and DONE must not start a second op.
        issue(P4, 32'h0F3A9C61, 32'h12345670, 1'b0, 32'h0712120F, 32'h01024061, 5, 1'b1, 1'b1);
        wait_done(5);
        chk("no_accept_in_done", {31'd0, busy}, 32'd0);
        valid = 1'b0;

        issue(P32, 32'hFFFFFFFF, 32'h80000001, 1'b0, 32'h00000001, 32'h7FFFFFFE, 33, 1'b1, 1'b0);
        wait_done(6);
        issue(P16, 32'h1234ABCD, 32'h00100100, 1'b0, 32'h012300AB, 32'h000400CD, 17, 1'b1, 1'b0);
        wait_done(7);
        issue(P8, 32'h80F90785, 32'hFF00FE03, 1'b1, exp_tq, exp_tr, 9, 1'b1, 1'b0);
        wait_done(8);

        // Non-one-hot width is rejected.
        pw = 5'b00110; rs1 = 32'd9; rs2 = 32'd2; valid = 1'b1;
        @(posedge g_clk);
        #1 valid = 1'b0;
        chk("reject_pw", {31'd0, busy}, 32'd0);
        repeat (3) @(posedge g_clk);
        #1;

        // Flush together with valid in IDLE drops the request.
        pw = P8; valid = 1'b1; flush = 1'b1;
        @(posedge g_clk);
        #1 valid = 1'b0; flush = 1'b0;
        chk("flush_drops_req", {31'd0, busy}, 32'd0);
        repeat (3) @(posedge g_clk);
        #1;

        // Asynchronous reset in the middle of BUSY.
        issue(P16, 32'h00FF00FF, 32'h00030005, 1'b0, 32'd0, 32'd0, 17, 1'b0, 1'b0);
        repeat (3) @(posedge g_clk);
        #2 g_resetn = 1'b0;
        #1;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_ready", {31'd0, ready}, 32'd0);
        chk("rst_result_q", result_q, 32'd0);
        chk("rst_result_r", result_r, 32'd0);
        #3 g_resetn = 1'b1;
        @(posedge g_clk);
        #1;

        issue(P2, 32'hE4E4E4E4, 32'h55555555, 1'b0, 32'hE4E4E4E4, 32'h00000000, 3, 1'b1, 1'b0);
        wait_done(9);
        repeat (5) @(posedge g_clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
